cheby_mem_master: RTL and testbench

CHEBY_MEM_MASTER -- requirements
Module: cheby_mem_master

---
 rtl/cheby_mem_master_if.sv | 51 +++++
 rtl/cheby_mem_master.sv | 119 +++++++++++
 tb/tb_cheby_mem_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cheby_mem_master_if.sv
// Bus bundle for cheby_mem_master: a command/response channel pair on the
// requester side and a strobe/done register-bank port on the memory side.
//
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising
// clock edge where valid and ready are both high; the sender keeps valid and
// its payload stable until that edge, and ready may be asserted at any time.
interface cheby_mem_master_if #(
    parameter int ADDR_WIDTH = 8
);
    // Command channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    // Register bank port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wr_data;
    logic                  mem_rd_mem;
    logic                  mem_wr_mem;
    logic [31:0]           mem_rd_data;
    logic                  mem_rd_done;
    logic                  mem_wr_done;

    // View of the master block itself
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_addr, mem_wr_data, mem_rd_mem, mem_wr_mem,
        input  mem_rd_data, mem_rd_done, mem_wr_done
    );

    // View of the environment: requester plus register bank
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_addr, mem_wr_data, mem_rd_mem, mem_wr_mem,
        output mem_rd_data, mem_rd_done, mem_wr_done
    );
endinterface

// File: rtl/cheby_mem_master.sv
// cheby_mem_master: turns one command at a time into a single-cycle read or
// write strobe towards a register bank, waits for the matching done pulse
// (bounded by TIMEOUT cycles) and returns the result as a response.
// All outputs come straight from flops.
module cheby_mem_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    cheby_mem_master_if.master bus,
    output logic [1:0]         state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t                state_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wr_data_q;
    logic                  mem_rd_mem_q;
    logic                  mem_wr_mem_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;
    logic [15:0]           cnt_q;

    logic                  done_hit;
    logic [15:0]           cnt_d;

    // Only the done pulse that belongs to the latched direction counts.
    assign done_hit = write_q ? bus.mem_wr_done : bus.mem_rd_done;
    assign cnt_d    = cnt_q + 16'd1;

    // Transaction FSM: accept in IDLE, strobe on WAIT entry, answer in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_rd_mem_q  <= 1'b0;
            mem_wr_mem_q  <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // Strobes are single-cycle: they only survive the accept edge.
            mem_rd_mem_q <= 1'b0;
            mem_wr_mem_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        write_q       <= bus.req_write;
                        mem_addr_q    <= bus.req_addr;
                        mem_wr_data_q <= bus.req_wdata;
                        mem_wr_mem_q  <= bus.req_write;
                        mem_rd_mem_q  <= !bus.req_write;
                        cnt_q         <= '0;
                        req_ready_q   <= 1'b0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    // A done in the final cycle still beats the timeout.
                    if (done_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= write_q ? 32'd0 : bus.mem_rd_data;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'd0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    // Done pulses are not looked at here, so a late answer
                    // cannot disturb the pending response.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.mem_rd_mem  = mem_rd_mem_q;
    assign bus.mem_wr_mem  = mem_wr_mem_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_cheby_mem_master.sv
// Bench for cheby_mem_master. The bench plays both the requester and the
// register bank; a plain array holds the bank contents, and the expected
// response timing and payload of each transaction come from the rules:
// a matching done at WAIT cycle d (d < TMO) answers at cycle d+1, otherwise
// the answer is a timeout error at cycle TMO. Inputs change on the falling
// edge and outputs are sampled there too.
module tb_cheby_mem_master;
    localparam int AW  = 8;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  state_dbg;
    logic [1:0]  idle_code;
    logic [31:0] bank [256];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    cheby_mem_master_if #(.ADDR_WIDTH(AW)) bus ();

    cheby_mem_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive_quiet();
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = 32'd0;
        bus.rsp_ready   = 1'b0;
        bus.mem_rd_done = 1'b0;
        bus.mem_wr_done = 1'b0;
        bus.mem_rd_data = $urandom;
    endtask

    // One full transaction starting on a falling edge in IDLE; returns on the
    // falling edge of the first IDLE cycle after the response handshake.
    // done_at / wrong_at are WAIT-relative cycle numbers (0 = strobe cycle,
    // -1 = never) for the matching and the opposite done pulse.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input int done_at, input int wrong_at, input int hold, input bit noise);
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          k;
        int          limit;
        bit          hs;
        if (done_at >= 0 && done_at < TMO) begin
            exp_lat   = done_at + 1;
            exp_err   = 1'b0;
            exp_rdata = wr ? 32'd0 : bank[addr];
        end else begin
            exp_lat   = TMO;
            exp_err   = 1'b1;
            exp_rdata = 32'd0;
        end
        if (wr) bank[addr] = wdata;

        n_vec++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;

        hs    = 1'b0;
        k     = 0;
        limit = exp_lat + hold + 4;
        while (!hs && k < limit) begin
            n_vec++;
            if ({bus.mem_wr_mem, bus.mem_rd_mem} !== ((k == 0) ? {wr, ~wr} : 2'b00)) begin
                n_err++;
                $display("FAIL strobe k=%0d: got wr=%b rd=%b want wr=%b rd=%b", k,
                         bus.mem_wr_mem, bus.mem_rd_mem, (k == 0) && wr, (k == 0) && !wr);
            end
            n_vec++;
            if (bus.req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL req_ready_busy k=%0d: got %b want 0", k, bus.req_ready);
            end
            n_vec++;
            if (k < exp_lat) begin
                if (bus.rsp_valid !== 1'b0 || bus.mem_addr !== addr || bus.mem_wr_data !== wdata) begin
                    n_err++;
                    $display("FAIL wait_phase k=%0d: got valid=%b addr=%h wdata=%h want valid=0 addr=%h wdata=%h",
                             k, bus.rsp_valid, bus.mem_addr, bus.mem_wr_data, addr, wdata);
                end
            end else begin
                if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, exp_err, exp_rdata} ||
                    state_dbg === idle_code) begin
                    n_err++;
                    $display("FAIL resp_phase k=%0d: got valid=%b err=%b rdata=%h state=%0d want valid=1 err=%b rdata=%h non-idle",
                             k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, state_dbg, exp_err, exp_rdata);
                end
            end
            bus.mem_rd_done = (!wr && k == done_at) || (wr && k == wrong_at);
            bus.mem_wr_done = (wr && k == done_at) || (!wr && k == wrong_at);
            bus.mem_rd_data = (!wr && k == done_at) ? bank[addr] : $urandom;
            bus.rsp_ready   = (k >= exp_lat + hold) ? 1'b1
                            : (k < exp_lat && noise && $urandom_range(0, 1) == 1);
            bus.req_valid   = noise && (k < exp_lat + hold) && ($urandom_range(0, 1) == 1);
            hs = bus.rsp_ready && bus.rsp_valid;
            @(negedge clk);
            k++;
        end
        drive_quiet();

        n_vec++;
        if (!hs) begin
            n_err++;
            $display("FAIL rsp_handshake: got none in %0d cycles want one at cycle %0d", limit, exp_lat + hold);
        end
        n_vec++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01 || state_dbg !== idle_code) begin
            n_err++;
            $display("FAIL back_to_idle: got valid=%b ready=%b state=%0d want valid=0 ready=1 state=%0d",
                     bus.rsp_valid, bus.req_ready, state_dbg, idle_code);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;
        bus.rsp_ready = 1'b0;
        bus.mem_rd_done = 1'b1;
        bus.mem_wr_done = 1'b1;
        bus.mem_rd_data = $urandom;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_rd_mem, bus.mem_wr_mem} !== 5'b10000 ||
            bus.rsp_rdata !== 32'd0 || bus.mem_addr !== '0 || bus.mem_wr_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_values: got ready=%b valid=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h want 1,0,0,0,0,0,0,0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_rd_mem, bus.mem_wr_mem,
                     bus.rsp_rdata, bus.mem_addr, bus.mem_wr_data);
        end
        idle_code = state_dbg;
        drive_quiet();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_rd_mem, bus.mem_wr_mem} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b valid=%b rd=%b wr=%b want 1,0,0,0",
                     bus.req_ready, bus.rsp_valid, bus.mem_rd_mem, bus.mem_wr_mem);
        end
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 8'h04, 32'h0000_2A5F, 1, -1, 0, 1'b0);
    endtask

    task automatic test_read_basic();
        run_txn(1'b0, 8'h04, 32'd0, 1, -1, 0, 1'b0);
    endtask

    task automatic test_timeout();
        // No answer, late done two cycles after the error response appears.
        run_txn(1'b0, 8'h21, 32'd0, TMO + 2, -1, 4, 1'b0);
        // Done in the last WAIT cycle wins over the timeout.
        run_txn(1'b0, 8'h22, 32'd0, TMO - 1, -1, 0, 1'b0);
        run_txn(1'b1, 8'h23, $urandom, TMO - 1, -1, 1, 1'b0);
    endtask

    task automatic test_hold();
        run_txn(1'b0, 8'h10, 32'd0, 1, -1, 10, 1'b1);
    endtask

    task automatic test_wrong_done();
        run_txn(1'b1, 8'h30, $urandom, 3, 0, 1, 1'b0);
        run_txn(1'b0, 8'h30, 32'd0, 2, 0, 0, 1'b0);
    endtask

    task automatic test_idle_done();
        bus.mem_rd_done = 1'b1;
        bus.mem_wr_done = 1'b1;
        bus.mem_rd_data = $urandom;
        @(negedge clk);
        bus.mem_rd_done = 1'b0;
        bus.mem_wr_done = 1'b0;
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_rd_mem, bus.mem_wr_mem} !== 4'b1000) begin
            n_err++;
            $display("FAIL idle_done: got ready=%b valid=%b rd=%b wr=%b want 1,0,0,0",
                     bus.req_ready, bus.rsp_valid, bus.mem_rd_mem, bus.mem_wr_mem);
        end
    endtask

    // Reset pulse rst_at cycles after the strobe of a read that gets no done.
    task automatic test_reset_mid(input int rst_at);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k < rst_at; k++) @(negedge clk);
        if (rst_at >= TMO) begin
            n_vec++;
            if ({bus.rsp_valid, bus.rsp_err} !== 2'b11) begin
                n_err++;
                $display("FAIL pre_reset_resp: got valid=%b err=%b want 1,1", bus.rsp_valid, bus.rsp_err);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_rd_mem, bus.mem_wr_mem} !== 5'b10000 ||
            bus.rsp_rdata !== 32'd0 || bus.mem_addr !== '0 || bus.mem_wr_data !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset at=%0d: got ready=%b valid=%b err=%b rdata=%h addr=%h wdata=%h want 1,0,0,0,0,0",
                     rst_at, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_addr, bus.mem_wr_data);
        end
        bus.mem_rd_done = 1'b1;
        bus.mem_rd_data = $urandom;
        @(negedge clk);
        bus.mem_rd_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({bus.req_ready, bus.rsp_valid, bus.mem_rd_mem, bus.mem_wr_mem} !== 4'b1000) begin
                n_err++;
                $display("FAIL post_reset_done k=%0d: got ready=%b valid=%b rd=%b wr=%b want 1,0,0,0",
                         k, bus.req_ready, bus.rsp_valid, bus.mem_rd_mem, bus.mem_wr_mem);
            end
            @(negedge clk);
        end
    endtask

    // With done in the strobe cycle and rsp_ready high, the IDLE cycle that
    // closes one transaction is already the accept cycle of the next, so
    // consecutive accepts are 3 edges apart (accept, WAIT, RESP, IDLE).
    task automatic test_back_to_back();
        int t0;
        for (int i = 0; i < 4; i++) begin
            t0 = cyc;
            run_txn(i[0], AW'(8'h40 + i), $urandom, 0, -1, 0, 1'b0);
            n_vec++;
            if (cyc - t0 !== 3) begin
                n_err++;
                $display("FAIL issue_period txn=%0d: got %0d edges want 3", i, cyc - t0);
            end
        end
    endtask

    task automatic test_random(input int n);
        bit          wr;
        logic [AW-1:0] a;
        int          d;
        int          w;
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 7));
            d  = int'($urandom_range(0, TMO + 2)) - 1;
            w  = int'($urandom_range(0, TMO + 1)) - 1;
            run_txn(wr, a, $urandom, d, w, int'($urandom_range(0, 3)), 1'b1);
            if ($urandom_range(0, 3) == 0) test_idle_done();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bank[i] = $urandom;
        idle_code = 2'd0;
        drive_quiet();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_timeout();
        test_hold();
        test_wrong_done();
        test_idle_done();
        test_reset_mid(1);
        run_txn(1'b0, 8'h04, 32'd0, 1, -1, 0, 1'b0);
        test_reset_mid(TMO + 1);
        run_txn(1'b1, 8'h05, $urandom, 0, -1, 0, 1'b0);
        test_back_to_back();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
